// File: rtl/wb_pkg.sv
// Shared Wishbone request types and sizing helpers
// for the request buffer slice.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic [WB_DW-1:0] dat;
  } wb_req_t;

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle.
// master drives the request, slave drives response and stall.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int SW = DATA_WIDTH / 8;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [SW-1:0]         sel;
  logic [DATA_WIDTH-1:0] dat_m;
  logic [DATA_WIDTH-1:0] dat_s;
  logic                  ack;
  logic                  err;
  logic                  stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, err, stall
  );

endinterface

// File: rtl/wb_req_buffer_skid_buf.sv
// Two-entry skid buffer (out_reg + skid_reg), strict FIFO.
// Ports: clk/rst, flush_i, in_valid_i/in_ready_o/in_data_i,
// out_valid_o/out_ready_i/out_data_o. in_ready_o is a flop.
module skid_buf
  import wb_pkg::*;
#(
  parameter type T = wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic out_vld_q, out_vld_d;
  logic skid_vld_q, skid_vld_d;
  T     out_q, out_d;
  T     skid_q, skid_d;
  logic pop;

  assign pop = out_vld_q & out_ready_i;

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || pop) begin
      // skid always drains first so order is kept
      out_vld_d = skid_vld_q | in_valid_i;
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = in_valid_i;
        if (in_valid_i) begin
          skid_d = in_data_i;
        end
      end else if (in_valid_i) begin
        out_d = in_data_i;
      end
    end else if (in_valid_i) begin
      skid_vld_d = 1'b1;
      skid_d     = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // payload needs no reset, valids qualify it
  always_ff @(posedge clk) begin
    out_q  <= out_d;
    skid_q <= skid_d;
  end

  assign in_ready_o  = ~skid_vld_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/wb_req_buffer.sv
// Pipelined Wishbone request buffer: registered request path,
// flop-only up.stall, outstanding cap, unregistered responses.
// Ports: clk, rst (sync, high), up (wb_if.slave), down (wb_if.master).
// ADDR_WIDTH/DATA_WIDTH must match the wb_pkg request widths.
module wb_req_buffer
  import wb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  up,
  wb_if.master down
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  wb_req_t       up_req;
  wb_req_t       out_req;
  logic          out_vld;
  logic          in_rdy;
  logic          stall;
  logic          accept;
  logic          resp;
  logic          dec;
  logic [CW-1:0] cnt_q, cnt_d;

  assign up_req = '{
    we:  up.we,
    adr: up.adr,
    sel: up.sel,
    dat: up.dat_m
  };

  // both terms are flops: no path from down.stall
  assign stall    = ~in_rdy | (cnt_q == MAX_C);
  assign up.stall = stall;
  assign accept   = up.cyc & up.stb & ~stall;

  skid_buf #(
    .T (wb_req_t)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (~up.cyc),
    .in_valid_i  (accept),
    .in_ready_o  (in_rdy),
    .in_data_i   (up_req),
    .out_valid_o (out_vld),
    .out_ready_i (up.cyc & ~down.stall),
    .out_data_o  (out_req)
  );

  assign down.cyc   = up.cyc;
  assign down.stb   = out_vld & up.cyc;
  assign down.we    = out_req.we;
  assign down.adr   = out_req.adr;
  assign down.sel   = out_req.sel;
  assign down.dat_m = out_req.dat;

  assign up.ack   = down.ack & up.cyc;
  assign up.err   = down.err & up.cyc;
  assign up.dat_s = down.dat_s;

  assign resp = down.ack | down.err;
  assign dec  = resp & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!up.cyc) begin
      cnt_d = '0;
    end else if (accept && !dec) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec && !accept) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_no_acc_stall: assert property (
    @(posedge clk) disable iff (rst)
    !(accept && up.stall));

  a_cnt_max: assert property (
    @(posedge clk) disable iff (rst)
    cnt_q <= MAX_C);

  a_stb_cyc: assert property (
    @(posedge clk) disable iff (rst)
    down.stb |-> down.cyc);

  a_req_stable: assert property (
    @(posedge clk) disable iff (rst)
    (down.stb && down.stall) |=>
    (!down.stb || $stable(out_req)));

  a_no_spurious: assert property (
    @(posedge clk) disable iff (rst)
    (up.cyc && resp) |-> (cnt_q != '0));

endmodule

// File: tb/tb_wb_req_buffer.sv
// Random scoreboard bench for wb_req_buffer.
// Driver pushes expectations, monitor pops and compares.
module tb_wb_req_buffer;
  import wb_pkg::*;

  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(WB_AW), .DATA_WIDTH(WB_DW)) up_if ();
  wb_if #(.ADDR_WIDTH(WB_AW), .DATA_WIDTH(WB_DW)) dn_if ();

  wb_req_buffer #(
    .MAX_OUTSTANDING (MAX),
    .ADDR_WIDTH      (WB_AW),
    .DATA_WIDTH      (WB_DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .up   (up_if),
    .down (dn_if)
  );

  typedef struct {
    logic        err;
    logic        we;
    logic [31:0] adr;
  } rsp_s;

  typedef struct {
    wb_req_t r;
    int      due;
  } pend_s;

  wb_req_t exp_req[$];
  rsp_s    exp_rsp[$];
  pend_s   spq[$];

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int n_pend = 0;
  int n_out = 0;
  int stall_seen = 0;
  int acc_cnt = 0;
  int abort_left = 0;
  int p_stb, p_stall, p_abort, p_rst, dmin, dmax;
  bit force_rst = 1'b1;
  bit mon_en = 1'b0;
  wb_req_t cur = '0;
  bit cur_stb = 1'b0;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[7:4] == 4'hF;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h",
               nm, cyc_n, act, exp);
    end
  endtask

  // monitor: compares what the DUT shows against the model
  always @(negedge clk) begin
    wb_req_t a;
    rsp_s    e;
    #1;
    if (mon_en) begin
      chk("stall", 128'(up_if.stall),
          128'((n_pend >= 2) || (n_out == MAX)));
      chk("stb", 128'(dn_if.stb),
          128'(up_if.cyc && (n_pend > 0)));
      chk("cyc", 128'(dn_if.cyc), 128'(up_if.cyc));
      if (dn_if.stb && exp_req.size() > 0) begin
        a = '{we: dn_if.we, adr: dn_if.adr,
              sel: dn_if.sel, dat: dn_if.dat_m};
        chk("req", 128'(a), 128'(exp_req[0]));
        if (!dn_if.stall) void'(exp_req.pop_front());
      end
      if (!up_if.cyc) begin
        chk("ack_drop", 128'({up_if.ack, up_if.err}), 128'(0));
      end else if (dn_if.ack || dn_if.err) begin
        if (exp_rsp.size() > 0) begin
          e = exp_rsp.pop_front();
          chk("ack", 128'(up_if.ack), 128'(!e.err));
          chk("err", 128'(up_if.err), 128'(e.err));
          if (!e.we && !e.err)
            chk("rdata", 128'(up_if.dat_s), 128'(rdata(e.adr)));
        end
      end else begin
        chk("no_rsp", 128'({up_if.ack, up_if.err}), 128'(0));
      end
      if (up_if.stall) stall_seen++;
    end
  end

  task automatic drive();
    rst = force_rst || ($urandom_range(99) < p_rst);
    if (abort_left > 0) begin
      up_if.cyc = 1'b0;
      up_if.stb = 1'b0;
      cur_stb = 1'b0;
      abort_left--;
    end else if ($urandom_range(99) < p_abort) begin
      up_if.cyc = 1'b0;
      up_if.stb = 1'b0;
      cur_stb = 1'b0;
      abort_left = int'($urandom_range(1));
    end else begin
      up_if.cyc = 1'b1;
      if (!cur_stb && $urandom_range(99) < p_stb) begin
        cur.we  = 1'($urandom_range(1));
        cur.adr = {22'h0, 8'($urandom_range(255)), 2'b00};
        cur.sel = 4'($urandom);
        cur.dat = $urandom;
        cur_stb = 1'b1;
      end
      up_if.stb = cur_stb;
    end
    up_if.we    = cur.we;
    up_if.adr   = cur.adr;
    up_if.sel   = cur.sel;
    up_if.dat_m = cur.dat;
    dn_if.stall = ($urandom_range(99) < p_stall);
    dn_if.ack   = 1'b0;
    dn_if.err   = 1'b0;
    dn_if.dat_s = $urandom;
    if (!up_if.cyc) begin
      dn_if.ack = ($urandom_range(3) == 0);
    end else if (!rst && spq.size() > 0 && spq[0].due <= cyc_n) begin
      dn_if.err = err_of(spq[0].r.adr);
      dn_if.ack = !dn_if.err;
      if (!spq[0].r.we) dn_if.dat_s = rdata(spq[0].r.adr);
    end
  endtask

  task automatic book();
    logic    acc, iss, rspv;
    wb_req_t r;
    acc  = up_if.cyc && up_if.stb && !up_if.stall && !rst;
    iss  = dn_if.stb && !dn_if.stall;
    rspv = up_if.cyc && !rst && (dn_if.ack || dn_if.err);
    if (rst || !up_if.cyc) begin
      n_pend = 0;
      n_out = 0;
      exp_req.delete();
      exp_rsp.delete();
      spq.delete();
    end else begin
      if (acc) begin
        exp_req.push_back(cur);
        exp_rsp.push_back('{err: err_of(cur.adr), we: cur.we,
                            adr: cur.adr});
        n_pend++;
        n_out++;
        acc_cnt++;
        cur_stb = 1'b0;
      end
      if (iss) begin
        r = '{we: dn_if.we, adr: dn_if.adr,
              sel: dn_if.sel, dat: dn_if.dat_m};
        spq.push_back('{r: r,
                        due: cyc_n + int'($urandom_range(dmax, dmin))});
        n_pend--;
      end
      if (rspv && spq.size() > 0) begin
        void'(spq.pop_front());
        n_out--;
      end
    end
    cyc_n++;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #2;
    book();
  endtask

  initial begin
    rst = 1'b1;
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0;
    up_if.adr = '0; up_if.sel = '0; up_if.dat_m = '0;
    dn_if.ack = 1'b0; dn_if.err = 1'b0;
    dn_if.stall = 1'b0; dn_if.dat_s = '0;
    p_stb = 100; p_stall = 0; p_abort = 0; p_rst = 0;
    dmin = 1; dmax = 1;
    repeat (3) step();
    force_rst = 1'b0;
    mon_en = 1'b1;

    // full rate, no back-pressure, 1-cycle acks
    stall_seen = 0;
    acc_cnt = 0;
    repeat (200) step();
    chk("no_stall", 128'(stall_seen), 128'(0));
    chk("thru", 128'(acc_cnt), 128'(200));

    // back-pressure and slow acks reach the cap
    p_stb = 80; p_stall = 40; dmin = 1; dmax = 6;
    stall_seen = 0;
    repeat (600) step();
    chk("stall_hit", 128'(stall_seen > 0), 128'(1));

    // aborts and resets mid-burst
    p_abort = 3; p_rst = 2; p_stall = 30; dmax = 4;
    repeat (800) step();

    // drain
    p_stb = 0; p_stall = 0; p_abort = 0; p_rst = 0;
    dmin = 1; dmax = 1;
    repeat (40) step();
    chk("drain_req", 128'(exp_req.size()), 128'(0));
    chk("drain_rsp", 128'(exp_rsp.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
